// File: rtl/regfile_game_mbox.sv
// Register file with bypassed dual read ports, plus a game-event FIFO that drains
// into a saturating score register exported with the status register to the display.
module regfile_game_mbox #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned SCORE_REG  = 29,
    parameter int unsigned STATUS_REG = 1,
    parameter int unsigned PTS_W      = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic              game_valid,
    input  logic [PTS_W-1:0]  game_points,
    output logic              game_ready,
    output logic [DATA_W-1:0] data_readScore,
    output logic [DATA_W-1:0] data_readStatus,
    output logic              score_saturated
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam logic [ADDR_W-1:0] SCORE_ADDR  = ADDR_W'(SCORE_REG);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(STATUS_REG);

    logic [DATA_W-1:0] regFile [NUM_REGS];
    logic [PTS_W-1:0]  fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic              scoreWrite;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   scoreSum;
    logic [DATA_W-1:0] scoreNext;

    // A CPU write to the score register owns that cycle; the drain waits.
    assign game_ready = (count < CNT_W'(FIFO_DEPTH));
    assign scoreWrite = ctrl_writeEnable && (ctrl_writeReg == SCORE_ADDR);
    assign push       = game_valid && game_ready;
    assign pop        = (count != '0) && !scoreWrite;

    always_comb begin
        scoreSum  = {1'b0, regFile[SCORE_ADDR]} + (DATA_W+1)'(fifoMem[rdPtr]);
        scoreNext = scoreSum[DATA_W] ? '1 : scoreSum[DATA_W-1:0];
    end

    always_comb begin
        data_readRegA = regFile[ctrl_readRegA];
        if (ctrl_readRegA == '0)
            data_readRegA = '0;
        else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA))
            data_readRegA = data_writeReg;
    end

    always_comb begin
        data_readRegB = regFile[ctrl_readRegB];
        if (ctrl_readRegB == '0)
            data_readRegB = '0;
        else if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB))
            data_readRegB = data_writeReg;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regFile[i] <= '0;
        end else begin
            if (ctrl_writeEnable && (ctrl_writeReg != '0))
                regFile[ctrl_writeReg] <= data_writeReg;
            if (pop)
                regFile[SCORE_ADDR] <= scoreNext;
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clock) begin
        if (push)
            fifoMem[wrPtr] <= game_points;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push)
                wrPtr <= wrPtr + PTR_W'(1);
            if (pop)
                rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            score_saturated <= 1'b0;
            data_readScore  <= '0;
            data_readStatus <= '0;
        end else begin
            if (scoreWrite)
                score_saturated <= 1'b0;
            else if (pop && scoreSum[DATA_W])
                score_saturated <= 1'b1;
            data_readScore  <= regFile[SCORE_ADDR];
            data_readStatus <= regFile[STATUS_ADDR];
        end
    end

endmodule

// File: tb/tb_regfile_game_mbox.sv
// Directed bench for regfile_game_mbox: register access, event draining, stalls,
// saturation and reset behaviour.
module tb_regfile_game_mbox;

    localparam logic [4:0] SCORE  = 5'd29;
    localparam logic [4:0] STATUS = 5'd1;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        game_valid;
    logic [2:0]  game_points;
    logic        game_ready;
    logic [31:0] data_readScore;
    logic [31:0] data_readStatus;
    logic        score_saturated;

    int total = 0;
    int bad   = 0;

    regfile_game_mbox dut (
        .clock(clock), .ctrl_reset_n(ctrl_reset_n),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB), .data_readRegA(data_readRegA),
        .data_readRegB(data_readRegB), .game_valid(game_valid),
        .game_points(game_points), .game_ready(game_ready),
        .data_readScore(data_readScore), .data_readStatus(data_readStatus),
        .score_saturated(score_saturated)
    );

    always #5 clock = ~clock;

    task automatic idle();
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        game_valid       = 1'b0;
        game_points      = '0;
        ctrl_readRegA    = '0;
        ctrl_readRegB    = SCORE;
    endtask

    task automatic cpuWrite(input logic [4:0] addr, input logic [31:0] val);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = addr;
        data_writeReg    = val;
    endtask

    task automatic test_reset();
        idle();
        ctrl_readRegA = STATUS;
        #1;
        total++; if (data_readRegB !== 32'd0) begin bad++; $display("FAIL reset_score got=%h exp=%h", data_readRegB, 32'd0); end
        total++; if (data_readScore !== 32'd0) begin bad++; $display("FAIL reset_export got=%h exp=%h", data_readScore, 32'd0); end
        total++; if (data_readStatus !== 32'd0) begin bad++; $display("FAIL reset_status got=%h exp=%h", data_readStatus, 32'd0); end
        total++; if (game_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", game_ready); end
        total++; if (score_saturated !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", score_saturated); end
    endtask

    task automatic test_rw();
        idle();
        cpuWrite(5'd5, 32'hDEADBEEF);
        ctrl_readRegA = 5'd5;
        #1;
        total++; if (data_readRegA !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_a got=%h exp=%h", data_readRegA, 32'hDEADBEEF); end
        @(negedge clock);
        cpuWrite(5'd0, 32'h1234);
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd5;
        #1;
        total++; if (data_readRegA !== 32'd0) begin bad++; $display("FAIL r0_bypass got=%h exp=%h", data_readRegA, 32'd0); end
        total++; if (data_readRegB !== 32'hDEADBEEF) begin bad++; $display("FAIL r5_stored got=%h exp=%h", data_readRegB, 32'hDEADBEEF); end
        @(negedge clock);
        cpuWrite(STATUS, 32'h55);
        #1;
        total++; if (data_readRegA !== 32'd0) begin bad++; $display("FAIL r0_read got=%h exp=%h", data_readRegA, 32'd0); end
        @(negedge clock);
        idle();
        total++; if (data_readStatus !== 32'd0) begin bad++; $display("FAIL status_lag got=%h exp=%h", data_readStatus, 32'd0); end
        @(negedge clock);
        total++; if (data_readStatus !== 32'h55) begin bad++; $display("FAIL status_export got=%h exp=%h", data_readStatus, 32'h55); end
    endtask

    task automatic test_burst();
        idle();
        cpuWrite(SCORE, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            idle();
            game_valid  = 1'b1;
            game_points = 3'(i);
            #1;
            total++; if (game_ready !== 1'b1) begin bad++; $display("FAIL burst_ready%0d got=%b exp=1", i, game_ready); end
        end
        @(negedge clock);
        idle();
        repeat (2) @(negedge clock);
        total++; if (data_readRegB !== 32'd21) begin bad++; $display("FAIL burst_sum got=%0d exp=21", data_readRegB); end
    endtask

    task automatic test_stall();
        idle();
        cpuWrite(SCORE, 32'd100);
        game_valid  = 1'b1;
        game_points = 3'd3;
        @(negedge clock);
        game_points = 3'd4;
        @(negedge clock);
        game_valid = 1'b0;
        @(negedge clock);
        idle();
        total++; if (data_readRegB !== 32'd100) begin bad++; $display("FAIL stall_hold got=%0d exp=100", data_readRegB); end
        @(negedge clock);
        total++; if (data_readRegB !== 32'd103) begin bad++; $display("FAIL stall_first got=%0d exp=103", data_readRegB); end
        @(negedge clock);
        total++; if (data_readRegB !== 32'd107) begin bad++; $display("FAIL stall_final got=%0d exp=107", data_readRegB); end
    endtask

    task automatic test_full();
        idle();
        cpuWrite(SCORE, 32'd0);
        game_valid  = 1'b1;
        game_points = 3'd1;
        repeat (4) @(negedge clock);
        game_points = 3'd2;
        #1;
        total++; if (game_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", game_ready); end
        @(negedge clock);
        #1;
        total++; if (game_ready !== 1'b0) begin bad++; $display("FAIL full_hold got=%b exp=0", game_ready); end
        idle();
        @(negedge clock);
        total++; if (game_ready !== 1'b1) begin bad++; $display("FAIL full_release got=%b exp=1", game_ready); end
        repeat (5) @(negedge clock);
        total++; if (data_readRegB !== 32'd4) begin bad++; $display("FAIL full_sum got=%0d exp=4", data_readRegB); end
    endtask

    task automatic test_back_to_back();
        idle();
        cpuWrite(SCORE, 32'd0);
        game_valid  = 1'b1;
        game_points = 3'd1;
        @(negedge clock);
        game_points = 3'd2;
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        game_points = 3'd3;
        #1;
        total++; if (game_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", game_ready); end
        @(negedge clock);
        game_valid = 1'b0;
        total++; if (data_readRegB !== 32'd1) begin bad++; $display("FAIL b2b_s1 got=%0d exp=1", data_readRegB); end
        @(negedge clock);
        total++; if (data_readRegB !== 32'd3) begin bad++; $display("FAIL b2b_s2 got=%0d exp=3", data_readRegB); end
        @(negedge clock);
        total++; if (data_readRegB !== 32'd6) begin bad++; $display("FAIL b2b_s3 got=%0d exp=6", data_readRegB); end
        @(negedge clock);
        total++; if (data_readRegB !== 32'd6) begin bad++; $display("FAIL b2b_s4 got=%0d exp=6", data_readRegB); end
    endtask

    task automatic test_wrap();
        int pts [10] = '{5, 7, 0, 3, 6, 1, 7, 2, 4, 6};
        int expSum = 0;
        idle();
        cpuWrite(SCORE, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            idle();
            game_valid  = 1'b1;
            game_points = 3'(pts[i]);
            expSum += pts[i];
        end
        @(negedge clock);
        idle();
        repeat (3) @(negedge clock);
        total++; if (data_readRegB !== 32'(expSum)) begin bad++; $display("FAIL wrap_model got=%0d exp=%0d", data_readRegB, expSum); end
        total++; if (data_readRegB !== 32'd41) begin bad++; $display("FAIL wrap_sum got=%0d exp=41", data_readRegB); end
    endtask

    task automatic test_saturate();
        idle();
        cpuWrite(SCORE, 32'hFFFFFFFE);
        @(negedge clock);
        idle();
        game_valid  = 1'b1;
        game_points = 3'd7;
        @(negedge clock);
        game_valid = 1'b0;
        @(negedge clock);
        total++; if (data_readRegB !== 32'hFFFFFFFF) begin bad++; $display("FAIL sat_value got=%h exp=%h", data_readRegB, 32'hFFFFFFFF); end
        total++; if (score_saturated !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b exp=1", score_saturated); end
        game_valid  = 1'b1;
        game_points = 3'd1;
        @(negedge clock);
        game_valid = 1'b0;
        total++; if (data_readScore !== 32'hFFFFFFFF) begin bad++; $display("FAIL sat_export got=%h exp=%h", data_readScore, 32'hFFFFFFFF); end
        @(negedge clock);
        total++; if (data_readRegB !== 32'hFFFFFFFF) begin bad++; $display("FAIL sat_again got=%h exp=%h", data_readRegB, 32'hFFFFFFFF); end
        total++; if (score_saturated !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", score_saturated); end
        cpuWrite(SCORE, 32'd0);
        #1;
        total++; if (data_readRegB !== 32'd0) begin bad++; $display("FAIL score_bypass got=%h exp=%h", data_readRegB, 32'd0); end
        @(negedge clock);
        idle();
        total++; if (score_saturated !== 1'b0) begin bad++; $display("FAIL sat_clear got=%b exp=0", score_saturated); end
    endtask

    task automatic test_reset_mid();
        idle();
        cpuWrite(SCORE, 32'hFFFFFFFF);
        @(negedge clock);
        cpuWrite(5'd7, 32'd9);
        game_valid  = 1'b1;
        game_points = 3'd1;
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        game_points = 3'd5;
        @(negedge clock);
        total++; if (score_saturated !== 1'b1) begin bad++; $display("FAIL pre_reset_sat got=%b exp=1", score_saturated); end
        idle();
        ctrl_reset_n  = 1'b0;
        ctrl_readRegA = 5'd7;
        #1;
        total++; if (data_readRegA !== 32'd0) begin bad++; $display("FAIL rst_r7 got=%h exp=%h", data_readRegA, 32'd0); end
        total++; if (data_readRegB !== 32'd0) begin bad++; $display("FAIL rst_score got=%h exp=%h", data_readRegB, 32'd0); end
        total++; if (data_readScore !== 32'd0) begin bad++; $display("FAIL rst_export got=%h exp=%h", data_readScore, 32'd0); end
        total++; if (game_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", game_ready); end
        total++; if (score_saturated !== 1'b0) begin bad++; $display("FAIL rst_sat got=%b exp=0", score_saturated); end
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        repeat (3) @(negedge clock);
        total++; if (data_readRegB !== 32'd0) begin bad++; $display("FAIL rst_lost got=%0d exp=0", data_readRegB); end
        total++; if (data_readScore !== 32'd0) begin bad++; $display("FAIL rst_lost_export got=%0d exp=0", data_readScore); end
    endtask

    initial begin
        idle();
        ctrl_reset_n = 1'b0;
        repeat (2) @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_rw();
        test_burst();
        test_stall();
        test_full();
        test_back_to_back();
        test_wrap();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
